// File: rtl/conv3x3_stream_pkg.sv
// Shared definitions for the 3x3 streaming convolution block.
//   - mode_e        : kernel select encoding carried on the 'mode' port
//   - COEF_SHIFT_IDX: coef_idx value that addresses the custom shift register
//   - fixed kernel tables (row-major, centre at index 4) and their shifts
package conv3x3_stream_pkg;

    typedef enum logic [1:0] {
        MODE_SHARPEN = 2'd0,
        MODE_GAUSS   = 2'd1,
        MODE_EDGE    = 2'd2,
        MODE_CUSTOM  = 2'd3
    } mode_e;

    localparam logic [3:0] COEF_SHIFT_IDX = 4'd9;

    // Fixed kernels fit comfortably in 5 signed bits (range -1..8).
    localparam int KCW = 5;
    typedef logic signed [KCW-1:0] kcoef_t;

    localparam kcoef_t K_SHARPEN [9] = '{
        5'sd0, -5'sd1, 5'sd0,
        -5'sd1, 5'sd5, -5'sd1,
        5'sd0, -5'sd1, 5'sd0
    };

    localparam kcoef_t K_GAUSS [9] = '{
        5'sd1, 5'sd2, 5'sd1,
        5'sd2, 5'sd4, 5'sd2,
        5'sd1, 5'sd2, 5'sd1
    };

    localparam kcoef_t K_EDGE [9] = '{
        -5'sd1, -5'sd1, -5'sd1,
        -5'sd1, 5'sd8, -5'sd1,
        -5'sd1, -5'sd1, -5'sd1
    };

    localparam logic [3:0] GAUSS_SHIFT = 4'd4;

    // Coefficient of a fixed kernel; custom mode has no fixed table.
    function automatic kcoef_t fixed_coef(input mode_e m, input logic [3:0] idx);
        case (m)
            MODE_SHARPEN: return K_SHARPEN[idx];
            MODE_GAUSS:   return K_GAUSS[idx];
            MODE_EDGE:    return K_EDGE[idx];
            default:      return 5'sd0;
        endcase
    endfunction

    // Normalising right shift of a fixed kernel.
    function automatic logic [3:0] fixed_shift(input mode_e m);
        case (m)
            MODE_GAUSS: return GAUSS_SHIFT;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// One-line delay RAM used to hold the previous image line.
// Each write to 'addr' returns the value stored at that address one line
// earlier, so with addr = column the output is the pixel directly above.
// Contents are deliberately not reset: stale data is never used because the
// row counter suppresses output until two fresh lines have been written.
// Ports:
//   clk  - clock
//   we   - write enable (input pixel accepted)
//   addr - column address
//   din  - pixel of the current line
//   dout - pixel at the same column of the previous line (combinational)
module conv3x3_linebuf
    import conv3x3_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    // Line storage: overwrite the column slot once its old value has been read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream ("valid" borders).
// Two line buffers supply the two lines above the incoming pixel; a 3x3
// window shifts on every accepted pixel and one registered result is emitted
// per complete window. Kernel mode and custom coefficients are latched from
// their shadow copies at start of frame.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   mode               - kernel select (sharpen/gaussian/edge/custom)
//   coef_we/idx/data   - custom shadow bank write (idx 0..8 coef, 9 shift)
//   s_valid/s_ready    - input handshake; s_sof marks first pixel of frame
//   s_pixel            - input pixel
//   m_valid/m_ready    - output handshake
//   m_pixel            - filtered, saturated output pixel
module conv3x3_stream
    import conv3x3_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int COEF_WIDTH  = 8,
    parameter int ACCW        = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   coef_we,
    input  logic [3:0]             coef_idx,
    input  logic [COEF_WIDTH-1:0]  coef_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_sof,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIXEL_WIDTH-1:0] m_pixel
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE  = {{(COEF_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [COEF_WIDTH-1:0] COEF_ZERO = {COEF_WIDTH{1'b0}};

    typedef logic [PIXEL_WIDTH-1:0] pix_t;
    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    // Position counters
    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic [1:0]    row_q, row_d, cur_row_s;

    // Window, row-major: index 0 = top-left (oldest line, oldest column)
    pix_t win_q [9];
    pix_t win_d [9];

    // Coefficient banks
    coef_t       sh_coef_q [9];
    coef_t       sh_coef_d [9];
    logic [3:0]  sh_shift_q, sh_shift_d;
    coef_t       act_coef_q [9];
    coef_t       act_coef_d [9];
    logic [3:0]  act_shift_q, act_shift_d;
    mode_e       act_mode_q, act_mode_d;

    // Output stage
    logic        m_valid_q, m_valid_d;
    pix_t        m_pixel_q, m_pixel_d;

    // Datapath
    logic        accept_s, produce_s;
    pix_t        lb0_out_s, lb1_out_s;
    logic signed [ACCW-1:0] coef_s [9];
    logic signed [ACCW-1:0] acc_s, shifted_s;
    logic [3:0]  shift_s;
    pix_t        sat_s;

    assign s_ready  = !m_valid_q || m_ready;
    assign accept_s = s_valid && s_ready;
    assign m_valid  = m_valid_q;
    assign m_pixel  = m_pixel_q;

    // Position of the offered pixel; a start-of-frame pixel is always (0,0).
    always_comb begin
        if (s_sof) begin
            cur_col_s = {CW{1'b0}};
            cur_row_s = 2'd0;
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
    end

    // Counter advance: col wraps at line end, row saturates at 2.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (cur_col_s == LAST_COL) begin
                col_d = {CW{1'b0}};
                row_d = (cur_row_s == 2'd2) ? 2'd2 : (cur_row_s + 2'd1);
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // A window is complete once two lines are buffered and three columns seen.
    always_comb begin
        if (accept_s && (cur_row_s == 2'd2) && (cur_col_s >= CW'(2))) begin
            produce_s = 1'b1;
        end else begin
            produce_s = 1'b0;
        end
    end

    conv3x3_linebuf #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb0 (
        .clk  (clk),
        .we   (accept_s),
        .addr (cur_col_s),
        .din  (s_pixel),
        .dout (lb0_out_s)
    );

    conv3x3_linebuf #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb1 (
        .clk  (clk),
        .we   (accept_s),
        .addr (cur_col_s),
        .din  (lb0_out_s),
        .dout (lb1_out_s)
    );

    // Window shift: new right column is {two lines up, one line up, incoming}.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb1_out_s;
            win_d[5] = lb0_out_s;
            win_d[8] = s_pixel;
        end else begin
            win_d = win_q;
        end
    end

    // Shadow bank writes; indices above the shift slot are ignored.
    always_comb begin
        sh_coef_d  = sh_coef_q;
        sh_shift_d = sh_shift_q;
        if (coef_we) begin
            for (int i = 0; i < 9; i++) begin
                if (coef_idx == 4'(i)) begin
                    sh_coef_d[i] = coef_data;
                end else begin
                    sh_coef_d[i] = sh_coef_q[i];
                end
            end
            if (coef_idx == COEF_SHIFT_IDX) begin
                sh_shift_d = coef_data[3:0];
            end else begin
                sh_shift_d = sh_shift_q;
            end
        end else begin
            sh_shift_d = sh_shift_q;
        end
    end

    // Frame-level settings snapshot taken with the start-of-frame pixel.
    always_comb begin
        act_coef_d  = act_coef_q;
        act_shift_d = act_shift_q;
        act_mode_d  = act_mode_q;
        if (accept_s && s_sof) begin
            act_coef_d  = sh_coef_q;
            act_shift_d = sh_shift_q;
            act_mode_d  = mode_e'(mode);
        end else begin
            act_mode_d  = act_mode_q;
        end
    end

    // Kernel coefficient selection, sign-extended to accumulator width.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            if (act_mode_q == MODE_CUSTOM) begin
                coef_s[i] = ACCW'(act_coef_q[i]);
            end else begin
                coef_s[i] = ACCW'(fixed_coef(act_mode_q, 4'(i)));
            end
        end
        if (act_mode_q == MODE_CUSTOM) begin
            shift_s = act_shift_q;
        end else begin
            shift_s = fixed_shift(act_mode_q);
        end
    end

    // Multiply-accumulate on the updated window, arithmetic shift, clamp.
    always_comb begin
        acc_s = {ACCW{1'b0}};
        for (int i = 0; i < 9; i++) begin
            acc_s = acc_s + ($signed({{(ACCW-PIXEL_WIDTH){1'b0}}, win_d[i]}) * coef_s[i]);
        end
        shifted_s = acc_s >>> shift_s;
        if (shifted_s[ACCW-1]) begin
            sat_s = {PIXEL_WIDTH{1'b0}};
        end else if (|shifted_s[ACCW-2:PIXEL_WIDTH]) begin
            sat_s = {PIXEL_WIDTH{1'b1}};
        end else begin
            sat_s = shifted_s[PIXEL_WIDTH-1:0];
        end
    end

    // Output register: a new result overrides a consumed one in the same cycle.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pixel_d = m_pixel_q;
        if (produce_s) begin
            m_valid_d = 1'b1;
            m_pixel_d = sat_s;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State registers with synchronous reset (line buffers excluded).
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= {CW{1'b0}};
            row_q       <= 2'd0;
            m_valid_q   <= 1'b0;
            m_pixel_q   <= {PIXEL_WIDTH{1'b0}};
            act_mode_q  <= MODE_SHARPEN;
            sh_shift_q  <= 4'd0;
            act_shift_q <= 4'd0;
            for (int i = 0; i < 9; i++) begin
                win_q[i]      <= {PIXEL_WIDTH{1'b0}};
                sh_coef_q[i]  <= (i == 4) ? COEF_ONE : COEF_ZERO;
                act_coef_q[i] <= (i == 4) ? COEF_ONE : COEF_ZERO;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            m_valid_q   <= m_valid_d;
            m_pixel_q   <= m_pixel_d;
            act_mode_q  <= act_mode_d;
            sh_shift_q  <= sh_shift_d;
            act_shift_q <= act_shift_d;
            win_q       <= win_d;
            sh_coef_q   <= sh_coef_d;
            act_coef_q  <= act_coef_d;
        end
    end

endmodule
